bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//  Takes an unsigned binary value and produces DIGITS packed BCD digits.
//  Sits directly upstream of the 8-digit seven-segment display top and
//  supplies its per-digit 4-bit inputs in place of hardcoded constants.
//  Runs on the 100 MHz system clock; its outputs are static between
//  conversions, so the display's slow refresh domain can read them directly.
// PARAMETERS
//  BIN_W   27  width of binary input; 27 bits covers 99_999_999; legal 1..32
//  DIGITS  8   number of BCD digits produced; legal 1..8
// PORTS
//  clk       in   1           system clock, rising edge
//  rst_n     in   1           asynchronous reset, active low
//  start     in   1           request a conversion of bin_in; sampled only in IDLE
//  bin_in    in   BIN_W       unsigned value; latched on the accepted start edge
//  busy      out  1           high while a conversion is in progress
//  done      out  1           single-cycle pulse when bcd_out/overflow update
//  overflow  out  1           last result exceeded 10^DIGITS-1 and was saturated
//  bcd_out   out  4*DIGITS    digit k at [4k+3:4k]; k=0 is ones; held between updates
// BEHAVIOUR
//  Reset:
//  - rst_n low forces, asynchronously, state=IDLE, busy=0, done=0,
//    overflow=0, bcd_out=0, and clears all scratch registers.
//  - Reset asserted mid-conversion aborts it; no done pulse; outputs read 0.
//  FSM, two states:
//  - IDLE: on start=1 at edge T0, latch bin_in into shift reg, clear BCD
//    scratch, count=0, compute ovf_pend = (bin_in > 10^DIGITS-1) -> CONV.
//  - CONV, each cycle: every scratch nibble >=5 gets +3, then the combined
//    {scratch, shift} register shifts left 1 bit; count increments.
//  - On the cycle count==BIN_W-1 the FSM returns to IDLE and registers:
//    done<=1; bcd_out <= ovf_pend ? all 4'h9 : final scratch; overflow<=ovf_pend.
//  Timing:
//  - busy=1 from edge T0+1 through the final CONV cycle, and 0 the cycle done=1.
//  - done=1 during exactly one cycle, beginning at edge T0+BIN_W
//    (default: 27 clocks after the accepted start edge).
//  - Latency is fixed; overflow inputs take the same time.
//  Handshake and boundaries:
//  - start while busy=1 is ignored; bin_in changes while busy have no effect.
//  - start=1 on the cycle done=1 (FSM already IDLE) is accepted. Back-to-back
//    throughput is one conversion per BIN_W+1 clocks when start is held high.
//  - bcd_out and overflow change only when done is pulsed, never mid-conversion.
//  - Width rules: scratch is 4*DIGITS bits. The per-nibble add is 4-bit with
//    no carry between nibbles (nibble <=9 after the add-3 and shift).
//    count is $clog2(BIN_W+1) bits. The 10^DIGITS-1 limit is an elaboration
//    constant. If 2^BIN_W-1 <= 10^DIGITS-1, overflow is constant 0.
//  - Digits above the value's magnitude read 0 (leading zeros, no blanking).
// TESTING
//  1 rst_n low 3 cycles, release; bin_in=12345678, start 1 cycle ->
//    busy 26 cycles, done at T0+27, bcd_out=32'h12345678, overflow=0.
//  2 bin_in=0 -> bcd_out=32'h00000000; bin_in=99999999 -> bcd_out=32'h99999999,
//    overflow=0.
//  3 bin_in=100000000 (fits 27b) -> overflow=1, bcd_out=32'h99999999; then
//    bin_in=42 -> overflow=0, bcd_out=32'h00000042.
//  4 start with 1234, then pulse start with 5678 while busy -> only one done,
//    bcd_out=32'h00001234.
//  5 start held high, bin_in=7 then 65 -> done every 28 cycles, 1 cycle wide;
//    bcd_out 0x7 then 0x65.
//  6 previous result 0x00000099; rst_n low at T0+10 of a new conversion ->
//    outputs 0 immediately, no done; after release, start 500 -> 32'h00000500.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: request/result bundle between a binary source and the BCD converter
interface bin2bcd_seq_if #(
  parameter int BIN_W = 27,
  parameter int DIGITS = 8
);
  logic start;
  logic [BIN_W-1:0] bin_in;
  logic busy;
  logic done;
  logic overflow;
  logic [4*DIGITS-1:0] bcd_out;
  modport master (output start, bin_in, input busy, done, overflow, bcd_out);
  modport slave (input start, bin_in, output busy, done, overflow, bcd_out);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to packed BCD converter, one bit per clock
module bin2bcd_seq #(
  parameter int BIN_W = 27,
  parameter int DIGITS = 8
) (
  input logic clk,
  input logic rst_n,
  bin2bcd_seq_if.slave bus
);
  typedef enum logic {IDLE, CONV} state_t;
  localparam int CW = $clog2(BIN_W + 1);
  localparam int SW = 4 * DIGITS;
  function automatic logic [63:0] max_bcd(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction
  localparam logic [63:0] LIMIT = max_bcd(DIGITS);
  state_t state;
  logic [CW-1:0] count;
  logic [BIN_W-1:0] shift, nxt_shift;
  logic [SW-1:0] scratch, adj, nxt_scratch;
  logic ovf_pend;
  logic last;
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = scratch[4*i+:4] >= 4'd5 ? scratch[4*i+:4] + 4'd3 : scratch[4*i+:4];
  end
  assign {nxt_scratch, nxt_shift} = {adj, shift} << 1;
  assign last = count == CW'(BIN_W - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      shift <= '0;
      scratch <= '0;
      ovf_pend <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.overflow <= 1'b0;
      bus.bcd_out <= '0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        bus.busy <= 1'b0;
        if (bus.start) begin
          state <= CONV;
          shift <= bus.bin_in;
          scratch <= '0;
          count <= '0;
          ovf_pend <= 64'(bus.bin_in) > LIMIT;
        end
      end else begin
        // busy trails the state by one edge so it drops exactly when done rises
        bus.busy <= !last;
        shift <= nxt_shift;
        scratch <= nxt_scratch;
        count <= count + CW'(1);
        if (last) begin
          state <= IDLE;
          bus.done <= 1'b1;
          bus.overflow <= ovf_pend;
          bus.bcd_out <= ovf_pend ? {DIGITS{4'h9}} : nxt_scratch;
        end
      end
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: randomized scoreboard bench for bin2bcd_seq against a decimal-arithmetic model
module tb_bin2bcd_seq;
  localparam int BIN_W = 27;
  localparam int DIGITS = 8;
  localparam int LAT = BIN_W;
  typedef struct {
    logic [31:0] bcd;
    logic ovf;
    int at;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int free_edge = 0;
  exp_t q[$];
  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();
  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(input logic [26:0] v, input int at);
    exp_t e;
    longint x;
    x = longint'(v);
    e.at = at;
    e.ovf = x > 64'd99999999;
    e.bcd = '0;
    for (int k = 0; k < DIGITS; k++) begin
      e.bcd[4*k+:4] = e.ovf ? 4'h9 : 4'(x % 10);
      x = x / 10;
    end
    return e;
  endfunction
  // drive one cycle's inputs; the start edge is the next posedge, accepted only if the converter is free
  task automatic cycle(input logic s, input logic [26:0] v);
    int n;
    bus.start = s;
    bus.bin_in = v;
    n = cyc + 1;
    if (s && n >= free_edge) begin
      q.push_back(model(v, n + LAT));
      free_edge = n + LAT + 1;
    end
    @(negedge clk);
  endtask
  task automatic drain();
    int t;
    t = 0;
    bus.start = 1'b0;
    while (q.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        if (q.size() == 0) chk("done_unexpected", 64'(bus.done), 64'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.at));
          chk("bcd_out", 64'(bus.bcd_out), 64'(e.bcd));
          chk("overflow", 64'(bus.overflow), 64'(e.ovf));
        end
      end else if (q.size() > 0 && cyc > q[0].at) begin
        chk("done_missing", 64'(bus.done), 64'd1);
        void'(q.pop_front());
      end
    end
  end
  initial begin
    int hi;
    logic [26:0] v;
    bus.start = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    chk("rst_bcd", 64'(bus.bcd_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    cycle(1'b1, 27'd12345678);
    chk("busy_at_t0", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;
    hi = 0;
    repeat (LAT) begin
      @(negedge clk);
      hi += int'(bus.busy);
    end
    chk("busy_cycles", 64'(hi), 64'd26);
    drain();
    cycle(1'b1, 27'd0);
    drain();
    cycle(1'b1, 27'd99999999);
    drain();
    cycle(1'b1, 27'd100000000);
    drain();
    cycle(1'b1, 27'd42);
    drain();
    cycle(1'b1, 27'd1234);
    repeat (5) cycle(1'b0, 27'($urandom));
    chk("hold_bcd", 64'(bus.bcd_out), 64'h42);
    cycle(1'b1, 27'd5678);
    repeat (4) cycle(1'b0, 27'($urandom));
    chk("busy_mid", 64'(bus.busy), 64'd1);
    drain();
    cycle(1'b1, 27'd7);
    repeat (LAT) cycle(1'b1, 27'd7);
    cycle(1'b1, 27'd65);
    repeat (LAT - 1) cycle(1'b1, 27'd65);
    drain();
    cycle(1'b1, 27'd99);
    drain();
    cycle(1'b1, 27'd777);
    repeat (9) cycle(1'b0, 27'd777);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    free_edge = 0;
    #1;
    chk("abort_bcd", 64'(bus.bcd_out), 64'd0);
    chk("abort_ovf", 64'(bus.overflow), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 3) cycle(1'b0, 27'd0);
    cycle(1'b1, 27'd500);
    drain();
    for (int i = 0; i < 40; i++) begin
      v = ($urandom_range(0, 3) == 0) ? 27'($urandom_range(100000000, 134217727)) : 27'($urandom_range(0, 99999999));
      cycle(1'b1, v);
      repeat ($urandom_range(0, 35)) cycle(($urandom_range(0, 3) == 0), 27'($urandom));
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
